// File: rtl/gate_sweep_checker_pkg.sv
// ============================================================================
// Module      : gate_chk_pkg
// Description : Shared types and constants for the two-input gate checkers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_chk_pkg;

    localparam int NUM_GATES = 7;
    localparam int NUM_VECS  = 4;

    localparam int GATE_AND  = 0;
    localparam int GATE_OR   = 1;
    localparam int GATE_NOT  = 2;
    localparam int GATE_NAND = 3;
    localparam int GATE_NOR  = 4;
    localparam int GATE_XOR  = 5;
    localparam int GATE_XNOR = 6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/gate_sweep_checker_if.sv
// ============================================================================
// Module      : gate_sweep_checker_if
// Description : Stimulus/response bundle between a gate DUT harness and checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gate_sweep_checker_if;
    import gate_chk_pkg::*;

    logic                 start;
    logic [NUM_GATES-1:0] gates_i;
    logic                 a_o;
    logic                 b_o;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [2:0]           err_count;
    logic [1:0]           first_fail_vec;
    logic [NUM_GATES-1:0] first_fail_mask;

    modport master (
        output start, gates_i,
        input  a_o, b_o, busy, done, pass, err_count, first_fail_vec, first_fail_mask
    );

    modport slave (
        input  start, gates_i,
        output a_o, b_o, busy, done, pass, err_count, first_fail_vec, first_fail_mask
    );

endinterface

`default_nettype wire

// File: rtl/gate_sweep_checker_ref_model.sv
// ============================================================================
// Module      : gate_ref_model
// Description : Combinational expected outputs of the 7-output two-input gate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_ref_model
    import gate_chk_pkg::*;
(
    input  logic [1:0]           i_vec,
    output logic [NUM_GATES-1:0] o_expected
);

    logic w_a;
    logic w_b;

    assign w_a = i_vec[1];
    assign w_b = i_vec[0];

    always_comb begin
        o_expected            = '0;
        o_expected[GATE_AND]  = w_a & w_b;
        o_expected[GATE_OR]   = w_a | w_b;
        o_expected[GATE_NOT]  = ~w_a;
        o_expected[GATE_NAND] = ~(w_a & w_b);
        o_expected[GATE_NOR]  = ~(w_a | w_b);
        o_expected[GATE_XOR]  = w_a ^ w_b;
        o_expected[GATE_XNOR] = ~(w_a ^ w_b);
    end

endmodule

`default_nettype wire

// File: rtl/gate_sweep_checker.sv
// ============================================================================
// Module      : gate_sweep_checker
// Description : Sweeps a/b through 00,01,10,11 and grades the seven gate outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_sweep_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
)(
    input  logic                clk,
    input  logic                rst,
    gate_sweep_checker_if.slave bus
);

    localparam logic [1:0] c_ST_IDLE   = S_IDLE;
    localparam logic [1:0] c_ST_SETTLE = S_SETTLE;
    localparam logic [1:0] c_ST_CHECK  = S_CHECK;
    localparam logic [1:0] c_ST_DONE   = S_DONE;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]       c_VEC_LAST = 2'(NUM_VECS - 1);

    logic [1:0]           r_state;
    logic [1:0]           r_vec;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [2:0]           r_err_count;
    logic [1:0]           r_first_fail_vec;
    logic [NUM_GATES-1:0] r_first_fail_mask;

    logic [NUM_GATES-1:0] w_expected;
    logic [NUM_GATES-1:0] w_mism;
    logic                 w_fail;

    gate_ref_model u_ref (
        .i_vec      (r_vec),
        .o_expected (w_expected)
    );

    assign w_mism = bus.gates_i ^ w_expected;
    // Case inequality so an X/Z on gates_i grades as a failure in simulation.
    assign w_fail = (w_mism !== '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= c_ST_IDLE;
            r_vec             <= 2'd0;
            r_cnt             <= '0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_err_count       <= 3'd0;
            r_first_fail_vec  <= 2'd0;
            r_first_fail_mask <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (bus.start) begin
                        r_state           <= c_ST_SETTLE;
                        r_vec             <= 2'd0;
                        r_cnt             <= '0;
                        r_busy            <= 1'b1;
                        r_done            <= 1'b0;
                        r_pass            <= 1'b0;
                        r_err_count       <= 3'd0;
                        r_first_fail_vec  <= 2'd0;
                        r_first_fail_mask <= '0;
                    end
                end
                c_ST_SETTLE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_ST_CHECK;
                    end
                end
                c_ST_CHECK: begin
                    if (w_fail) begin
                        r_err_count <= r_err_count + 3'd1;
                        if (r_err_count == 3'd0) begin
                            r_first_fail_vec  <= r_vec;
                            r_first_fail_mask <= w_mism;
                        end
                    end
                    if (r_vec == c_VEC_LAST) begin
                        r_state <= c_ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_err_count == 3'd0) && !w_fail;
                    end else begin
                        r_state <= c_ST_SETTLE;
                        r_vec   <= r_vec + 2'd1;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.a_o             = r_vec[1];
    assign bus.b_o             = r_vec[0];
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.pass            = r_pass;
    assign bus.err_count       = r_err_count;
    assign bus.first_fail_vec  = r_first_fail_vec;
    assign bus.first_fail_mask = r_first_fail_mask;

endmodule

`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
// ============================================================================
// Module      : tb_gate_sweep_checker
// Description : Randomized self-checking bench with gate stubs and sweep model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_sweep_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   mode = 0;      // 0 good, 1 nand=and, 2 xnor stuck 0, 3 one cycle late
    int   checks = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    gate_sweep_checker_if bus0 ();
    gate_sweep_checker_if bus1 ();

    gate_sweep_checker #(.SETTLE_CYCLES(2), .CNT_W(4)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    gate_sweep_checker #(.SETTLE_CYCLES(1), .CNT_W(4)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    function automatic logic [6:0] golden(input int v);
        int a, b;
        logic [6:0] r;
        a = v / 2;
        b = v % 2;
        r[0] = (a + b == 2);
        r[1] = (a + b >= 1);
        r[2] = (a == 0);
        r[3] = !(a + b == 2);
        r[4] = !(a + b >= 1);
        r[5] = (a != b);
        r[6] = (a == b);
        return r;
    endfunction

    function automatic logic [6:0] faulty(input int m, input int v);
        logic [6:0] r;
        r = golden(v);
        if (m == 1) r[3] = r[0];
        if (m == 2) r[6] = 1'b0;
        return r;
    endfunction

    // Gate stubs standing in for the logic_gate block under test
    logic [6:0] late0 = '0;
    logic [6:0] late1 = '0;
    always @(posedge clk) begin
        late0 <= golden(int'({bus0.a_o, bus0.b_o}));
        late1 <= golden(int'({bus1.a_o, bus1.b_o}));
    end
    always_comb bus0.gates_i = (mode == 3) ? late0 : faulty(mode, int'({bus0.a_o, bus0.b_o}));
    always_comb bus1.gates_i = (mode == 3) ? late1 : faulty(mode, int'({bus1.a_o, bus1.b_o}));
    assign bus0.start = start;
    assign bus1.start = start;

    logic [16:0] act [2];
    assign act[0] = {bus0.a_o, bus0.b_o, bus0.busy, bus0.done, bus0.pass, bus0.err_count,
                     bus0.first_fail_vec, bus0.first_fail_mask};
    assign act[1] = {bus1.a_o, bus1.b_o, bus1.busy, bus1.done, bus1.pass, bus1.err_count,
                     bus1.first_fail_vec, bus1.first_fail_mask};

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, a, e, $time);
        end
    endtask

    // Behavioural sweep model: phase 0 idle, 1 sweeping, 2 done; k = edges since start
    int         m_phase [2] = '{0, 0};
    int         m_k     [2] = '{0, 0};
    int         m_err   [2] = '{0, 0};
    int         m_ffv   [2] = '{0, 0};
    logic [6:0] m_ffm   [2] = '{7'd0, 7'd0};
    int         m_set   [2] = '{2, 1};
    bit         m_valid = 1'b0;

    always begin
        @(posedge clk);
        if (rst) m_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            int s1, v, pv;
            logic [6:0] smp, mm;
            s1 = m_set[i] + 1;
            if (rst) begin
                m_phase[i] = 0; m_k[i] = 0; m_err[i] = 0; m_ffv[i] = 0; m_ffm[i] = '0;
            end else if (m_phase[i] != 1 && start) begin
                m_phase[i] = 1; m_k[i] = 0; m_err[i] = 0; m_ffv[i] = 0; m_ffm[i] = '0;
            end else if (m_phase[i] == 1) begin
                m_k[i]++;
                if (m_k[i] % s1 == 0) begin
                    v   = m_k[i] / s1 - 1;
                    pv  = (m_k[i] - 2) / s1;
                    smp = (mode == 3) ? golden(pv) : faulty(mode, v);
                    mm  = golden(v) ^ smp;
                    if (mm != 0) begin
                        if (m_err[i] == 0) begin
                            m_ffv[i] = v;
                            m_ffm[i] = mm;
                        end
                        m_err[i]++;
                    end
                    if (v == 3) m_phase[i] = 2;
                end
            end
        end
        #1;
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                int ev;
                logic [16:0] exp_v;
                ev = (m_phase[i] == 0) ? 0 : (m_phase[i] == 2) ? 3 : m_k[i] / (m_set[i] + 1);
                exp_v = {2'(ev), (m_phase[i] == 1), (m_phase[i] == 2),
                         (m_phase[i] == 2 && m_err[i] == 0), 3'(m_err[i]),
                         2'(m_ffv[i]), m_ffm[i]};
                check(i == 0 ? "outputs_s2" : "outputs_s1", 32'(act[i]), 32'(exp_v));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_sweep(input int offset, output int c0, output int c1);
        c0 = -1;
        c1 = -1;
        for (int n = offset + 1; n <= offset + 60; n++) begin
            @(posedge clk);
            #1;
            if (c0 < 0 && bus0.done) c0 = n;
            if (c1 < 0 && bus1.done) c1 = n;
            if (c0 >= 0 && c1 >= 0) break;
        end
        if (c0 < 0 || c1 < 0) begin
            checks++;
            fails++;
            $display("FAIL sweep_timeout actual=%0d/%0d required=done", c0, c1);
        end
        @(negedge clk);
    endtask

    initial begin
        int c0, c1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        mode = 0;
        pulse_start();
        wait_sweep(0, c0, c1);
        check("latency_s2", c0, 12);
        check("latency_s1", c1, 8);
        check("good_pass", bus0.pass, 1);
        check("good_mask", bus0.first_fail_mask, 0);

        mode = 1;
        pulse_start();
        wait_sweep(0, c0, c1);
        check("nand_err", bus0.err_count, 4);
        check("nand_pass", bus0.pass, 0);
        check("nand_vec", bus0.first_fail_vec, 0);
        check("nand_mask", bus0.first_fail_mask, 7'b0001000);

        mode = 2;
        pulse_start();
        wait_sweep(0, c0, c1);
        check("xnor_err", bus0.err_count, 2);
        check("xnor_vec", bus0.first_fail_vec, 0);
        check("xnor_mask", bus0.first_fail_mask, 7'b1000000);

        // Re-pulse start mid-sweep; then restart from DONE with a good DUT
        pulse_start();
        repeat (4) @(negedge clk);
        pulse_start();
        wait_sweep(5, c0, c1);
        check("repulse_latency", c0, 12);
        check("repulse_err", bus0.err_count, 2);
        mode = 0;
        pulse_start();
        wait_sweep(0, c0, c1);
        check("rerun_err", bus0.err_count, 0);
        check("rerun_pass", bus0.pass, 1);

        // Reset at cycle 7 of a failing sweep
        mode = 1;
        pulse_start();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy", bus0.busy, 0);
        check("rst_done", bus0.done, 0);
        check("rst_ab", {bus0.a_o, bus0.b_o}, 0);
        check("rst_err", bus0.err_count, 0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        mode = 0;
        @(negedge clk);
        pulse_start();
        wait_sweep(0, c0, c1);
        check("post_rst_latency", c0, 12);
        check("post_rst_pass", bus0.pass, 1);

        mode = 3;
        pulse_start();
        wait_sweep(0, c0, c1);
        check("late_s2_pass", bus0.pass, 1);

        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(0, 3));
            for (int c = 0; c < int'($urandom_range(1, 30)); c++) begin
                start = ($urandom_range(0, 3) == 0);
                rst   = ($urandom_range(0, 19) == 0);
                @(negedge clk);
            end
            start = 1'b0;
            rst   = 1'b0;
            repeat (20) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
